// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types for the hazard scoreboard: write kinds, stall
//               causes and the per-kind result latency helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        WK_NONE   = 2'd0,
        WK_ALU    = 2'd1,
        WK_LOAD   = 2'd2,
        WK_MULDIV = 2'd3
    } wkind_t;

    typedef enum logic [1:0] {
        C_NONE   = 2'd0,
        C_RAW    = 2'd1,
        C_WAW    = 2'd2,
        C_MDBUSY = 2'd3
    } cause_t;

    // Extra cycles before a writer's result can be forwarded to a
    // non-branch consumer in EX.
    function automatic int lat(input wkind_t kind, input int loadLat, input int mdLat);
        case (kind)
            WK_LOAD:   return loadLat;
            WK_MULDIV: return mdLat;
            default:   return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : ID-stage instruction description in, pipeline control out.
//               master : drives the ID-stage fields and kill
//               slave  : the scoreboard, drives enables/flush/cause/perf
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 16
) ();
    import hazard_pkg::*;

    logic              id_valid;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_is_branch;
    logic              id_taken;
    logic              id_is_jump;
    wkind_t            id_wkind;
    logic [REG_W-1:0]  id_wr_addr;
    logic              kill;

    logic              pc_en;
    logic              ifid_en;
    logic              idex_bubble;
    logic              ifid_flush;
    cause_t            stall_cause;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
               id_taken, id_is_jump, id_wkind, id_wr_addr, kill,
        input  pc_en, ifid_en, idex_bubble, ifid_flush, stall_cause, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
               id_taken, id_is_jump, id_wkind, id_wr_addr, kill,
        output pc_en, ifid_en, idex_bubble, ifid_flush, stall_cause, stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/hazard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sb_entry
// Description : One scoreboard slot: cycles left until a pending register
//               write lands. Load beats decrement; clear beats both.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clear       - pipeline flush, zeroes the slot
//               i_load        - a writer to this register issues now
//               i_loadVal     - countdown value for that writer
//               o_cnt         - current countdown
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sb_entry #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_loadVal,
    output logic      [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_loadVal;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage interlock. Tracks pending register writes, detects
//               RAW / WAW / multiply-divide busy hazards, drives PC and
//               pipeline-register enables and counts stall cycles.
// Ports       : clk, reset    - clock, synchronous active-high reset
//               bus (slave)   - id_* instruction fields and kill in;
//                               pc_en, ifid_en, idex_bubble, ifid_flush,
//                               stall_cause, stall_cycles out
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    parameter int BR_EXTRA = 1,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_scoreboard_if.slave bus
);

    localparam int               NUM_REGS   = 2 ** REG_W;
    localparam logic [CNT_W-1:0] C_BR_EXTRA = CNT_W'(BR_EXTRA);
    localparam logic [CNT_W-1:0] C_MD_LAT   = CNT_W'(MD_LAT);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    logic [CNT_W-1:0]  w_cnt [NUM_REGS];
    logic [CNT_W-1:0]  w_wrLat;
    logic [CNT_W-1:0]  r_mdCnt;
    logic [PERF_W-1:0] r_stallCycles;
    logic              w_isWriter;
    logic              w_raw;
    logic              w_waw;
    logic              w_mdBusy;
    logic              w_stall;
    logic              w_issue;
    logic              w_load;

    // r0 is hard-wired zero and never pending.
    assign w_cnt[0] = '0;

    // Countdown loaded on issue: BR_EXTRA is added so that a branch, which
    // compares in ID, keeps waiting after a non-branch consumer may go.
    assign w_wrLat    = CNT_W'(lat(bus.id_wkind, LOAD_LAT, MD_LAT) + BR_EXTRA);
    assign w_isWriter = (bus.id_wkind != WK_NONE) && (bus.id_wr_addr != '0);

    always_comb begin
        w_raw = 1'b0;
        if (bus.id_uses_rs && (bus.id_rs != '0)) begin
            w_raw = bus.id_is_branch ? (w_cnt[bus.id_rs] != '0)
                                     : (w_cnt[bus.id_rs] > C_BR_EXTRA);
        end
        if (bus.id_uses_rt && (bus.id_rt != '0)) begin
            if (bus.id_is_branch ? (w_cnt[bus.id_rt] != '0)
                                 : (w_cnt[bus.id_rt] > C_BR_EXTRA)) begin
                w_raw = 1'b1;
            end
        end
    end

    // An older write still in flight would land after this one.
    assign w_waw    = w_isWriter && (w_cnt[bus.id_wr_addr] > w_wrLat);
    // md_cnt == 1 means the unit frees up as the new op reaches EX.
    assign w_mdBusy = (bus.id_wkind == WK_MULDIV) && (r_mdCnt > C_ONE);

    assign w_stall = bus.id_valid && (w_raw || w_waw || w_mdBusy) && !bus.kill;
    assign w_issue = bus.id_valid && !w_stall && !bus.kill;
    assign w_load  = w_issue && w_isWriter;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        hazard_sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk       (clk),
            .rst       (reset),
            .i_clear   (bus.kill),
            .i_load    (w_load && (bus.id_wr_addr == REG_W'(i))),
            .i_loadVal (w_wrLat),
            .o_cnt     (w_cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || bus.kill) begin
            r_mdCnt <= '0;
        end else if (w_issue && (bus.id_wkind == WK_MULDIV)) begin
            r_mdCnt <= C_MD_LAT;
        end else if (r_mdCnt != '0) begin
            r_mdCnt <= r_mdCnt - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCycles <= '0;
        end else if (w_stall && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + PERF_W'(1);
        end
    end

    always_comb begin
        bus.pc_en       = !w_stall;
        bus.ifid_en     = !w_stall;
        bus.idex_bubble = w_stall || bus.kill;
        bus.ifid_flush  = w_issue && (bus.id_is_jump || (bus.id_is_branch && bus.id_taken));
        bus.stall_cause = C_NONE;
        if (w_stall) begin
            if (w_raw) begin
                bus.stall_cause = C_RAW;
            end else if (w_waw) begin
                bus.stall_cause = C_WAW;
            end else begin
                bus.stall_cause = C_MDBUSY;
            end
        end
    end

    assign bus.stall_cycles = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. Directed scenario
//               tasks plus a randomized run against a time-stamp model:
//               each register remembers the absolute cycle its pending
//               write becomes ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int LOAD_LAT = 1;
    localparam int MD_LAT   = 4;
    localparam int BR_EXTRA = 1;
    localparam int PW       = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_W(5), .PERF_W(PW)) bus ();

    hazard_scoreboard #(
        .REG_W(5), .LOAD_LAT(LOAD_LAT), .MD_LAT(MD_LAT),
        .BR_EXTRA(BR_EXTRA), .CNT_W(4), .PERF_W(PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: absolute ready cycle per register / for the MD unit.
    longint nowC = 0;
    longint readyAt [32];
    longint mdFree = 0;
    int     perfM = 0;

    function automatic longint remOf(input int r);
        if (r == 0) return 0;
        return (readyAt[r] > nowC) ? readyAt[r] - nowC : 0;
    endfunction

    function automatic longint latOf(input wkind_t k);
        case (k)
            WK_LOAD:   return LOAD_LAT;
            WK_MULDIV: return MD_LAT;
            default:   return 0;
        endcase
    endfunction

    function automatic logic srcBlocks(input int r);
        if (bus.id_is_branch) return remOf(r) != 0;
        return remOf(r) > longint'(BR_EXTRA);
    endfunction

    task automatic model_eval(output logic st, output cause_t cause);
        logic raw, waw, md;
        longint mdRem;
        raw = (bus.id_uses_rs && srcBlocks(int'(bus.id_rs))) ||
              (bus.id_uses_rt && srcBlocks(int'(bus.id_rt)));
        waw = (bus.id_wkind != WK_NONE) && (bus.id_wr_addr != 0) &&
              (remOf(int'(bus.id_wr_addr)) > latOf(bus.id_wkind) + BR_EXTRA);
        mdRem = (mdFree > nowC) ? mdFree - nowC : 0;
        md = (bus.id_wkind == WK_MULDIV) && (mdRem > 1);
        st = bus.id_valid && (raw || waw || md) && !bus.kill;
        cause = !st ? C_NONE : raw ? C_RAW : waw ? C_WAW : C_MDBUSY;
    endtask

    // Advance one clock, updating the model from the inputs held this cycle.
    task automatic tick();
        logic st, iss;
        cause_t c;
        model_eval(st, c);
        iss = bus.id_valid && !st && !bus.kill;
        @(posedge clk);
        if (reset || bus.kill) begin
            foreach (readyAt[i]) readyAt[i] = 0;
            mdFree = 0;
        end else if (iss) begin
            if (bus.id_wkind != WK_NONE && bus.id_wr_addr != 0)
                readyAt[bus.id_wr_addr] = nowC + 1 + latOf(bus.id_wkind) + BR_EXTRA;
            if (bus.id_wkind == WK_MULDIV)
                mdFree = nowC + 1 + MD_LAT;
        end
        if (reset) perfM = 0;
        else if (st && perfM < (1 << PW) - 1) perfM++;
        nowC++;
        #1;
    endtask

    task automatic set_id(input logic v, input wkind_t k, input int wr,
                          input int rs, input logic urs, input int rt, input logic urt,
                          input logic br, input logic tk, input logic jmp);
        bus.id_valid     = v;
        bus.id_wkind     = k;
        bus.id_wr_addr   = 5'(wr);
        bus.id_rs        = 5'(rs);
        bus.id_uses_rs   = urs;
        bus.id_rt        = 5'(rt);
        bus.id_uses_rt   = urt;
        bus.id_is_branch = br;
        bus.id_taken     = tk;
        bus.id_is_jump   = jmp;
    endtask

    task automatic idle();
        set_id(1'b0, WK_NONE, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.kill = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL reset_pc_en got %b want 1", bus.pc_en); end
        checks++; if (bus.ifid_en !== 1'b1) begin errors++; $display("FAIL reset_ifid_en got %b want 1", bus.ifid_en); end
        checks++; if (bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bus.idex_bubble); end
        checks++; if (bus.ifid_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", bus.ifid_flush); end
        checks++; if (bus.stall_cause !== C_NONE) begin errors++; $display("FAIL reset_cause got %0d want %0d", bus.stall_cause, C_NONE); end
        checks++; if (bus.stall_cycles !== '0) begin errors++; $display("FAIL reset_perf got %0d want 0", bus.stall_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, WK_LOAD, 8, 1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL load_issue pc_en got %b want 1", bus.pc_en); end
        tick();
        set_id(1'b1, WK_ALU, 3, 8, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL load_use_stall pc_en got %b want 0", bus.pc_en); end
        checks++; if (bus.idex_bubble !== 1'b1) begin errors++; $display("FAIL load_use_bubble got %b want 1", bus.idex_bubble); end
        checks++; if (bus.stall_cause !== C_RAW) begin errors++; $display("FAIL load_use_cause got %0d want %0d", bus.stall_cause, C_RAW); end
        tick();
        #1;
        checks++; if (bus.pc_en !== 1'b1 || bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL load_use_release pc_en %b bubble %b want 1 0", bus.pc_en, bus.idex_bubble); end
        tick();
    endtask

    task automatic test_alu_branch();
        do_reset();
        set_id(1'b1, WK_ALU, 9, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, WK_NONE, 0, 9, 1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (bus.pc_en !== 1'b0 || bus.ifid_flush !== 1'b0) begin errors++; $display("FAIL alu_br_stall pc_en %b flush %b want 0 0", bus.pc_en, bus.ifid_flush); end
        tick();
        #1;
        checks++; if (bus.pc_en !== 1'b1 || bus.ifid_flush !== 1'b1) begin errors++; $display("FAIL alu_br_flush pc_en %b flush %b want 1 1", bus.pc_en, bus.ifid_flush); end
        tick();
        idle();
        #1;
        checks++; if (bus.ifid_flush !== 1'b0) begin errors++; $display("FAIL alu_br_flush_once got %b want 0", bus.ifid_flush); end
    endtask

    // Presents the current instruction until it issues and returns the
    // number of stall cycles seen, each required to carry 'want'.
    task automatic count_stalls(input cause_t want, input string tag, output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (bus.pc_en === 1'b1) break;
            n++;
            checks++;
            if (bus.stall_cause !== want) begin errors++; $display("FAIL %s_cause got %0d want %0d", tag, bus.stall_cause, want); end
            tick();
        end
        tick();
    endtask

    task automatic test_muldiv_b2b();
        int n;
        do_reset();
        set_id(1'b1, WK_MULDIV, 0, 4, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, WK_MULDIV, 0, 6, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        count_stalls(C_MDBUSY, "md_b2b", n);
        checks++; if (n != MD_LAT - 1) begin errors++; $display("FAIL md_b2b_cycles got %0d want %0d", n, MD_LAT - 1); end
    endtask

    task automatic test_waw();
        int n;
        do_reset();
        set_id(1'b1, WK_MULDIV, 5, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, WK_ALU, 5, 1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        count_stalls(C_WAW, "waw", n);
        checks++; if (n != MD_LAT) begin errors++; $display("FAIL waw_cycles got %0d want %0d", n, MD_LAT); end
    endtask

    task automatic test_r0();
        do_reset();
        set_id(1'b1, WK_LOAD, 0, 1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, WK_NONE, 0, 0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.pc_en !== 1'b1 || bus.stall_cause !== C_NONE) begin errors++; $display("FAIL r0_no_stall pc_en %b cause %0d want 1 0", bus.pc_en, bus.stall_cause); end
        tick();
    endtask

    task automatic test_kill();
        do_reset();
        set_id(1'b1, WK_MULDIV, 8, 1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, WK_ALU, 3, 8, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL kill_pre_stall pc_en got %b want 0", bus.pc_en); end
        tick();
        bus.kill = 1'b1;
        #1;
        checks++; if (bus.pc_en !== 1'b1 || bus.ifid_en !== 1'b1 || bus.idex_bubble !== 1'b1) begin errors++; $display("FAIL kill_outputs pc %b ifid %b bubble %b want 1 1 1", bus.pc_en, bus.ifid_en, bus.idex_bubble); end
        checks++; if (bus.stall_cause !== C_NONE) begin errors++; $display("FAIL kill_cause got %0d want 0", bus.stall_cause); end
        tick();
        bus.kill = 1'b0;
        set_id(1'b1, WK_NONE, 0, 8, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL kill_cleared pc_en got %b want 1", bus.pc_en); end
        tick();
        // Issue attempt and kill together: nothing may be recorded.
        set_id(1'b1, WK_LOAD, 10, 1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        set_id(1'b1, WK_MULDIV, 0, 10, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL kill_issue_dropped pc_en got %b want 1", bus.pc_en); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, WK_MULDIV, 0, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        #1;
        checks++; if (bus.stall_cause !== C_MDBUSY) begin errors++; $display("FAIL rst_mid_pre cause got %0d want %0d", bus.stall_cause, C_MDBUSY); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.pc_en !== 1'b1 || bus.idex_bubble !== 1'b0 || bus.stall_cause !== C_NONE) begin errors++; $display("FAIL rst_mid_clear pc %b bubble %b cause %0d want 1 0 0", bus.pc_en, bus.idex_bubble, bus.stall_cause); end
        checks++; if (bus.stall_cycles !== '0) begin errors++; $display("FAIL rst_mid_perf got %0d want 0", bus.stall_cycles); end
        tick();
    endtask

    task automatic test_saturation();
        int seen = 0;
        do_reset();
        // Self-dependent muldiv: long RAW stalls with one issue in between.
        set_id(1'b1, WK_MULDIV, 1, 1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            #1;
            if (bus.pc_en === 1'b0) seen++;
            tick();
        end
        checks++; if (seen < (1 << PW) + 3) begin errors++; $display("FAIL sat_stalls_seen got %0d want >= %0d", seen, (1 << PW) + 3); end
        checks++; if (bus.stall_cycles !== {PW{1'b1}}) begin errors++; $display("FAIL sat_perf got %0d want %0d", bus.stall_cycles, (1 << PW) - 1); end
    endtask

    task automatic test_random();
        logic st, iss;
        cause_t c;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_id(($urandom_range(0, 3) != 0), wkind_t'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                   ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 15) == 0));
            bus.kill = ($urandom_range(0, 15) == 0);
            #1;
            model_eval(st, c);
            iss = bus.id_valid && !st && !bus.kill;
            checks++; if (bus.pc_en !== !st || bus.ifid_en !== !st) begin errors++; $display("FAIL rnd_en cyc %0d pc %b ifid %b want %b", i, bus.pc_en, bus.ifid_en, !st); end
            checks++; if (bus.idex_bubble !== (st || bus.kill)) begin errors++; $display("FAIL rnd_bubble cyc %0d got %b want %b", i, bus.idex_bubble, st || bus.kill); end
            checks++; if (bus.ifid_flush !== (iss && (bus.id_is_jump || (bus.id_is_branch && bus.id_taken)))) begin errors++; $display("FAIL rnd_flush cyc %0d got %b", i, bus.ifid_flush); end
            checks++; if (bus.stall_cause !== c) begin errors++; $display("FAIL rnd_cause cyc %0d got %0d want %0d", i, bus.stall_cause, c); end
            checks++; if (int'(bus.stall_cycles) != perfM) begin errors++; $display("FAIL rnd_perf cyc %0d got %0d want %0d", i, bus.stall_cycles, perfM); end
            tick();
        end
        idle();
    endtask

    initial begin
        foreach (readyAt[i]) readyAt[i] = 0;
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_alu_branch();
        test_muldiv_b2b();
        test_waw();
        test_r0();
        test_kill();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised interlock unit for the MIPS pipeline: tracks pending register writes with per-register countdown counters and detects RAW, WAW and multiply/divide structural hazards. It also covers branches resolved in ID and jump/taken-branch flushes. It sits beside the ID stage and drives the PC, IF/ID and ID/EX control-enable lines. A saturating stall counter is included for performance measurement.

## Interface
- REG_W, 5, register address width; NUM_REGS = 2**REG_W
- LOAD_LAT, 1, extra ID-wait cycles for a dependent non-branch consumer of a load
- MD_LAT, 4, multiply/divide latency in cycles; also the unit busy time
- BR_EXTRA, 1, additional wait for a branch in ID, because the comparator sits in ID
- CNT_W, 4, counter width; must hold MD_LAT+BR_EXTRA
- PERF_W, 16, stall-counter width
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_rs, id_rt  in  REG_W  source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_is_branch  in  1  conditional branch, compared in ID
- id_taken  in  1  branch outcome, valid with id_is_branch
- id_is_jump  in  1  unconditional jump
- id_wkind  in  2  wkind_t: WK_NONE, WK_ALU, WK_LOAD, WK_MULDIV
- id_wr_addr  in  REG_W  destination register
- kill  in  1  pipeline flush from later stages
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- idex_bubble  out  1  zero control into ID/EX
- ifid_flush  out  1  clear IF/ID
- stall_cause  out  2  cause_t: C_NONE, C_RAW, C_WAW, C_MDBUSY
- stall_cycles  out  PERF_W  saturating stall count

## Operation
- The scoreboard is cnt[r] for each r in 1..NUM_REGS-1. Register 0 is never tracked and never causes a stall.
- lat(kind): WK_ALU = 0, WK_LOAD = LOAD_LAT, WK_MULDIV = MD_LAT.
- On issue with wkind != WK_NONE and id_wr_addr != 0: cnt[id_wr_addr] <= lat + BR_EXTRA.
- Every other nonzero counter decrements by 1 per cycle. Issue overrides the decrement for the same register.
- RAW hazard: a used source s has cnt[s] > BR_EXTRA for a non-branch consumer, or cnt[s] != 0 for a branch consumer.
- WAW hazard: a writer's destination has cnt[d] > lat + BR_EXTRA, i.e. an older write would land later.
- MD busy: md_cnt loads MD_LAT on a muldiv issue and decrements to 0. A new WK_MULDIV stalls while md_cnt > 1.
- stall = id_valid & (RAW | WAW | MDBUSY) & !kill.
- Cause priority for stall_cause: RAW > WAW > MDBUSY.
- issue = id_valid & !stall & !kill.
- On stall: pc_en = 0, ifid_en = 0, idex_bubble = 1, ifid_flush = 0.
- ifid_flush = issue & (id_is_jump | (id_is_branch & id_taken)). Flush is never asserted during a stall.
- kill: all cnt and md_cnt <= 0 next cycle, and no issue this cycle. Output idex_bubble = 1, pc_en = 1, ifid_en = 1.
- stall_cycles increments on each stall cycle and saturates at all-ones.

## Timing
- All outputs are combinational from ID inputs plus registered state, with zero-cycle decision latency.
- Reset: all cnt = 0, md_cnt = 0, stall_cycles = 0.
- Outputs after reset with id_valid = 0: pc_en = 1, ifid_en = 1, idex_bubble = 0, ifid_flush = 0, stall_cause = C_NONE.
- A load followed by a dependent ALU op costs exactly LOAD_LAT stall cycles.
- A load followed by a dependent branch costs LOAD_LAT + BR_EXTRA stall cycles.
- An ALU op followed by a dependent branch costs BR_EXTRA stall cycles.
- Back-to-back muldiv ops are spaced MD_LAT-1 stall cycles.
- Issue and kill in the same cycle: kill wins and nothing is recorded.
- Reset mid-stall clears the stall in the next cycle.

## Structure
- hazard_pkg holds wkind_t, cause_t and the lat() function.
- The parameters remain module-level.
- One sub-module, hazard_sb_entry, implements a single load/decrement counter and is instantiated NUM_REGS-1 times via generate.
- The top level holds md_cnt, the hazard reduction, output decode and the perf counter.

## Test plan
- Load to r8, then `add` reading r8 (LOAD_LAT=1): exactly 1 cycle with pc_en=0, idex_bubble=1, stall_cause=C_RAW; issues on the next cycle.
- ALU write to r9, then `beq` on r9 taken: 1 stall cycle, then ifid_flush=1 for exactly one cycle.
- `mult` then `div` (MD_LAT=4): 3 stall cycles with C_MDBUSY.
- Muldiv writing r5, next an ALU write to r5: WAW stall until cnt[r5] ≤ BR_EXTRA, with stall_cause=C_WAW.
- Load to r0, then a consumer of r0: no stall.
- kill asserted during a load-use stall: the next cycle has no stall, and all counters read 0.
- Force 2**PERF_W+3 stall cycles: stall_cycles holds at all-ones.
- Assert reset during an MD-busy stall: all outputs return to their reset values one cycle later.
